// File: rtl/axi_lite_read_arbiter_if.sv
// AXI4-Lite read channel (AR/R) bundle shared by the arbiter and the
// slave-side interconnect.
interface axi_lite_read_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [2:0]            M_AXI_ARPROT;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        output M_AXI_ARADDR,
        output M_AXI_ARPROT,
        output M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA,
        input  M_AXI_RRESP,
        input  M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_ARADDR,
        input  M_AXI_ARPROT,
        input  M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA,
        output M_AXI_RRESP,
        output M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel between NUM_REQ
// requesters, one outstanding read at a time, with a saturating error count.
module axi_lite_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [7:0]                    err_count,
    axi_lite_read_arbiter_if.master       m_axi
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = GW + 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_e;

    state_e                  state_q;
    logic [GW-1:0]           rr_ptr_q;
    logic [GW-1:0]           grant_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_err_q;
    logic                    busy_q;
    logic [7:0]              err_cnt_q;

    logic                    win_found_d;
    logic [GW-1:0]           win_idx_d;
    logic [NUM_REQ-1:0]      win_oh_d;
    logic [PW-1:0]           pos;
    logic                    unused_rresp0;

    assign unused_rresp0 = m_axi.M_AXI_RRESP[0];

    // Rotating priority search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        pos         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + PW'(k);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!win_found_d && req_valid[pos[GW-1:0]]) begin
                win_found_d = 1'b1;
                win_idx_d   = pos[GW-1:0];
            end
        end
    end

    always_comb begin
        win_oh_d = '0;
        if (win_found_d) begin
            win_oh_d = ONE << win_idx_d;
        end
    end

    assign req_ready = (state_q == S_IDLE && !ARESET) ? win_oh_d : '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        grant_q   <= win_idx_d;
                        araddr_q  <= req_addr[int'(win_idx_d)*ADDR_WIDTH +: ADDR_WIDTH];
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_data_q  <= m_axi.M_AXI_RDATA;
                        rsp_err_q   <= m_axi.M_AXI_RRESP[1];
                        rsp_valid_q <= ONE << grant_q;
                        if (m_axi.M_AXI_RRESP[1] && err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    rr_ptr_q <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_err              = rsp_err_q;
    assign busy                 = busy_q;
    assign err_count            = err_cnt_q;
    assign m_axi.M_AXI_ARADDR   = araddr_q;
    assign m_axi.M_AXI_ARPROT   = 3'b000;
    assign m_axi.M_AXI_ARVALID  = arvalid_q;
    assign m_axi.M_AXI_RREADY   = rready_q;

endmodule

// File: doc/axi_lite_read_arbiter.md
# axi_lite_read_arbiter

Round-robin arbiter that shares one AXI4-Lite master read channel (AR/R) between NUM_REQ local requesters. It sits between the sequential-read logic and the slave-side interconnect and serialises requests with one outstanding transaction at a time. Read data and error status are returned to the requester that won the grant. The block also keeps a saturating count of error responses for system status.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 only)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request; held until req_ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  request addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot acceptance pulse to the granted requester
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_data  out  DATA_WIDTH  read data; valid while any rsp_valid bit is high
- rsp_err  out  1  RRESP[1] of the returned beat; valid with rsp_valid
- busy  out  1  high in every state except IDLE
- err_count  out  8  count of responses with RRESP[1]=1; saturates at 255
- M_AXI_ARADDR  out  ADDR_WIDTH  read address
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address accepted
- M_AXI_RDATA  in  DATA_WIDTH  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  data valid
- M_AXI_RREADY  out  1  data ready

## Operation
- The state machine has four states: IDLE, ADDR, DATA and RESP.
- IDLE, any req_valid set:
  - Pick the first set bit starting at pointer `rr_ptr`, searching upward with wrap.
  - Assert req_ready for the winner in the same cycle (combinational from req_valid and rr_ptr).
  - Register the winner's address into ARADDR and its index into `grant`.
  - Next state is ADDR.
- IDLE, no request: req_ready = 0 and the block stays in IDLE.
- ADDR:
  - ARVALID = 1. ARADDR and ARVALID are held stable until ARREADY.
  - On ARVALID & ARREADY, go to DATA.
- DATA:
  - RREADY = 1.
  - On RVALID, register RDATA into rsp_data and RRESP[1] into rsp_err.
  - If RRESP[1] = 1, increment err_count unless it is already 255.
  - Go to RESP.
- RESP:
  - rsp_valid[grant] = 1 for exactly this cycle.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - Go to IDLE.
- rsp_data and rsp_err hold their value until the next response.
- RRESP[0] is ignored, so OKAY and EXOKAY count as success.
- Requests that lose arbitration are not dropped. The requester keeps req_valid high and waits.
- A requester that deasserts req_valid before its req_ready pulse simply loses its turn. This is legal.
- Simultaneous requests: exactly one grant per IDLE visit. With all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0,…

## Timing
- Reset (ARESET = 1 at a clock edge) forces:
  - state = IDLE, rr_ptr = 0;
  - ARVALID = 0, RREADY = 0;
  - ARADDR = 0, rsp_data = 0, rsp_err = 0;
  - rsp_valid = 0, err_count = 0, busy = 0.
- req_ready is 0 during reset.
- Reset mid-transaction abandons the transaction and issues no rsp_valid. The interconnect and slave are reset by the same system reset.
- Latency, request accepted in cycle T (req_ready high):
  - ARVALID is high from T+1.
  - If ARREADY is high at T+1 and RVALID at T+2, then rsp_valid is at T+3 and IDLE at T+4.
  - Minimum spacing between consecutive req_ready pulses is 4 cycles.
- Each cycle of ARREADY low in ADDR, or RVALID low in DATA, adds one cycle of latency. There is no timeout.
- busy = 1 from T+1 through the RESP cycle inclusive.
- AXI rules:
  - ARVALID does not depend on ARREADY.
  - RREADY is asserted only in DATA.
  - Never more than one outstanding AR.

## Test plan
- Single request: req_valid = 4'b0010, req_addr[1] = 0x4000_0010, slave returns 0xDEAD_BEEF / OKAY.
  - Expect req_ready = 0010 at T, ARADDR = 0x4000_0010 with ARVALID at T+1, rsp_valid = 0010 at T+3.
  - Expect rsp_data = 0xDEAD_BEEF, rsp_err = 0, err_count = 0.
- All four requesting continuously: the grant order is 0,1,2,3,0,1. The ARADDR sequence matches the per-requester addresses.
- Backpressure: ARREADY is delayed 3 cycles and RVALID a further 5. ARADDR and ARVALID stay stable throughout, RREADY is high only in DATA, and rsp_valid arrives at T+11.
- Error response: RRESP = 2'b10 (SLVERR). Expect rsp_err = 1, err_count 0→1. After 256 error responses err_count = 255 and does not wrap.
- Reset in DATA: assert ARESET while waiting on RVALID.
  - Next cycle: busy = 0, RREADY = 0, rsp_valid = 0, err_count = 0.
  - After reset, a request from requester 2 is granted first (rr_ptr = 0, only 2 active).
- Pointer fairness: requester 3 is granted, then requesters 0 and 3 both request. Requester 0 wins (rr_ptr = 0 after wrap), then requester 3.
